sparse_current_accumulator: RTL and testbench
=============================================

// Module: sparse_current_accumulator
// PURPOSE
//   Upstream stage of the LIF neuron (mvm). Takes an 8-bit input spike vector and
//   forms the neuron's input current as the sum of per-input signed synaptic
//   weights, visiting only the set bits. Each cycle handles one active input, so
//   a sparse vector costs fewer cycles. The result is clamped to 0..255 and
//   drives the neuron's 8-bit current input through a valid/ready handshake.
// PARAMETERS
//   N_IN       8    number of input spike lines / weight registers
//   W_WIDTH    8    signed weight width (two's complement)
//   CUR_WIDTH  8    unsigned output current width
//   ACC_WIDTH  W_WIDTH+$clog2(N_IN)  signed accumulator width (11 at defaults)
//   SKIP_WIDTH 16   width of the skipped-operation counter
// PORTS
//   clk           in   1           clock; all state updates on rising edge
//   rst           in   1           synchronous, active-high reset
//   w_load        in   1           write w_data into weight[w_addr] this cycle
//   w_addr        in   3           weight index, 0..N_IN-1
//   w_data        in   W_WIDTH     signed weight value
//   in_valid      in   1           in_spikes is valid
//   in_ready      out  1           block can accept a spike vector
//   in_spikes     in   N_IN        spike vector; bit i selects weight[i]
//   out_valid     out  1           out_current is valid
//   out_ready     in   1           downstream neuron consumes out_current
//   out_current   out  CUR_WIDTH   clamped summed current
//   skip_count    out  SKIP_WIDTH  total zero bits skipped; saturates at all-ones
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; in_ready=1; out_valid=0; out_current=0;
//     acc=0; mask=0; skip_count=0; every weight=0. A reset in mid-SCAN or
//     mid-DONE drops the operation in flight without producing output.
//   FSM IDLE -> SCAN -> DONE -> IDLE
//   IDLE:  in_ready=1. On in_valid&in_ready:
//            mask<=in_spikes; acc<=0;
//            skip_count += N_IN-popcount(in_spikes) (saturating).
//          If in_spikes==0, go directly to DONE. Otherwise go to SCAN.
//   SCAN:  in_ready=0. Each cycle: idx=lowest set bit of mask;
//            acc += sign-extended weight[idx]; clear mask[idx].
//          If this clears the last set bit, go to DONE.
//   DONE:  out_valid=1; out_current=clamp(acc): acc<0 gives 0, acc>255 gives 255,
//          otherwise acc[7:0]. out_current is held stable while out_valid=1.
//          On out_ready go to IDLE with out_valid=0 on the next cycle.
//          out_current keeps its last value after the handshake.
//   Latency: accept at edge k gives out_valid at edge k+P+1, where P=popcount (P=0 gives k+1).
//     There is no input overlap: in_ready=0 in SCAN and DONE.
//   Weight writes are accepted in any state and take effect on the next edge.
//     A SCAN read of the weight being written in that same cycle returns the old value.
//   w_addr >= N_IN is ignored (no write).
//   Arithmetic: ACC_WIDTH is sized so the sum cannot overflow
//     (8 x -128 = -1024 minimum, 8 x 127 = 1016 maximum).
//     Clamping is applied only at the output.
//   in_valid while in_ready=0 is ignored. The upstream must hold in_valid high until accepted.
// STRUCTURE
//   Shared package sca_pkg:
//     - state enum {IDLE, SCAN, DONE}
//     - N_IN, W_WIDTH, CUR_WIDTH, ACC_WIDTH defaults
//     - function sat_current(acc)
//   Sub-module lsb_priority_enc (N_IN in; idx[2:0], any out):
//     combinational lowest-set-bit finder used in SCAN.
//   Weights are a flat register array in this module; no memory macro.
// TESTING
//   1 Reset, load w[i]=i+1, send 8'hFF -> out_valid at accept+9, out_current=36, skip_count=0.
//   2 Send 8'h00 -> out_valid at accept+1, out_current=0, skip_count=+8.
//   3 Load all weights=-128, send 8'hFF -> out_current=0 (negative clamp).
//     Load all weights=127 -> out_current=255 (positive clamp).
//   4 w[3]=-20, w[5]=50, send 8'h28 -> out_current=30, exactly 3 cycles accept->valid.
//   5 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_current stable,
//     in_ready=0, new in_valid ignored.
//   6 Assert rst mid-SCAN -> next cycle IDLE, in_ready=1, out_valid=0, weights=0.
//     Write w[2] during SCAN of bit 2 -> old value summed.

Source files
------------

// File: rtl/sca_pkg.sv
// Shared types, widths and helpers for the sparse current accumulator.
// Saturation and popcount live here so the top stays a plain FSM + datapath.
package sca_pkg;

  localparam int N_IN       = 8;
  localparam int W_WIDTH    = 8;
  localparam int CUR_WIDTH  = 8;
  localparam int IDX_WIDTH  = $clog2(N_IN);
  localparam int ACC_WIDTH  = W_WIDTH + IDX_WIDTH;
  localparam int SKIP_WIDTH = 16;

  localparam logic signed [ACC_WIDTH-1:0] CUR_MAX = ACC_WIDTH'((1 << CUR_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Clamp the signed running sum into the unsigned current range.
  function automatic logic [CUR_WIDTH-1:0] sat_current(input logic signed [ACC_WIDTH-1:0] acc);
    if (acc[ACC_WIDTH-1]) return '0;
    if (acc > CUR_MAX)    return '1;
    return acc[CUR_WIDTH-1:0];
  endfunction

  function automatic logic [IDX_WIDTH:0] popcount(input logic [N_IN-1:0] v);
    logic [IDX_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c += (IDX_WIDTH+1)'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sparse_current_accumulator_lsb_priority_enc.sv
// Combinational lowest-set-bit finder; picks the next active input to visit.
module lsb_priority_enc
  import sca_pkg::*;
(
  input  logic [N_IN-1:0]      vec_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/sparse_current_accumulator.sv
// Sums signed weights of the set spike bits, one active bit per cycle,
// and hands the clamped current downstream over a valid/ready handshake.
module sparse_current_accumulator
  import sca_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_load,
  input  logic [IDX_WIDTH-1:0]        w_addr,
  input  logic signed [W_WIDTH-1:0]   w_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN-1:0]             in_spikes,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CUR_WIDTH-1:0]        out_current,
  output logic [SKIP_WIDTH-1:0]       skip_count
);

  state_e                      state_q, state_d;
  logic [N_IN-1:0]             mask_q, mask_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CUR_WIDTH-1:0]        cur_q, cur_d;
  logic [SKIP_WIDTH-1:0]       skip_q, skip_d;
  logic [SKIP_WIDTH:0]         skip_sum;
  logic [IDX_WIDTH:0]          zero_bits;
  logic signed [W_WIDTH-1:0]   weight_q [N_IN];

  logic [IDX_WIDTH-1:0] scan_idx;
  logic                 scan_any;

  lsb_priority_enc u_enc (
    .vec_i (mask_q),
    .idx_o (scan_idx),
    .any_o (scan_any)
  );

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_current = cur_q;
  assign skip_count  = skip_q;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    cur_d     = cur_q;
    skip_d    = skip_q;
    zero_bits = (IDX_WIDTH+1)'(N_IN) - popcount(in_spikes);
    skip_sum  = {1'b0, skip_q} + (SKIP_WIDTH+1)'(zero_bits);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d = in_spikes;
          acc_d  = '0;
          skip_d = skip_sum[SKIP_WIDTH] ? '1 : skip_sum[SKIP_WIDTH-1:0];
          if (in_spikes == '0) begin
            cur_d   = '0;
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_any) begin
          // A same-cycle weight write lands at the edge, so this reads the old value.
          acc_d            = acc_q + ACC_WIDTH'(weight_q[scan_idx]);
          mask_d[scan_idx] = 1'b0;
        end
        if (mask_d == '0) begin
          cur_d   = sat_current(acc_d);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      acc_q   <= '0;
      cur_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      cur_q   <= cur_d;
      skip_q  <= skip_d;
    end
  end

  // NOTE: the weight array is a handful of flops, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= '0;
    end else if (w_load && ({1'b0, w_addr} < (IDX_WIDTH+1)'(N_IN))) begin
      weight_q[w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_sparse_current_accumulator.sv
// Self-checking bench: hand tables, corner sequences and randomized vectors
// compared against an arithmetic model of weighted spike sums.
module tb_sparse_current_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_load;
  logic [2:0]  w_addr;
  logic [7:0]  w_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_spikes;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_current;
  logic [15:0] skip_count;

  int n_vec = 0;
  int n_err = 0;
  int w_m [8];
  int skip_m = 0;

  sparse_current_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .w_load      (w_load),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_spikes   (in_spikes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_current (out_current),
    .skip_count  (skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] spikes;
    int         exp_cur;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_w(input int a, input int d);
    w_load = 1'b1;
    w_addr = a[2:0];
    w_data = d[7:0];
    tick();
    w_load = 1'b0;
    w_m[a] = d;
  endtask

  function automatic int model_cur(input logic [7:0] sp);
    int s = 0;
    for (int i = 0; i < 8; i++) if (sp[i]) s += w_m[i];
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic int ones(input logic [7:0] sp);
    int c = 0;
    for (int i = 0; i < 8; i++) if (sp[i]) c++;
    return c;
  endfunction

  // Send one vector, wait for the result, optionally stall the consumer
  // while pushing a competing input that must be ignored.
  task automatic run_vector(input logic [7:0] sp, input int hold,
                            output int cur, output int lat);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_spikes = sp;
    tick();
    in_valid = 1'b0;
    skip_m   = skip_m + 8 - ones(sp);
    if (skip_m > 65535) skip_m = 65535;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    cur = int'(out_current);
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_spikes = ~sp;
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_current", int'(out_current), cur);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("current_kept", int'(out_current), cur);
  endtask

  initial begin
    vec_t tbl [6];
    int   cur, lat;
    logic [7:0] sp;

    rst = 1'b1; w_load = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_spikes = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) w_m[i] = 0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_current", int'(out_current), 0);
    check("rst_skip", int'(skip_count), 0);
    rst = 1'b0;

    // Weights w[i]=i+1: sums are easy to derive by hand.
    for (int i = 0; i < 8; i++) load_w(i, i + 1);
    tbl[0] = '{8'hFF, 36, 9};
    tbl[1] = '{8'h00,  0, 1};
    tbl[2] = '{8'h01,  1, 2};
    tbl[3] = '{8'h80,  8, 2};
    tbl[4] = '{8'h0A,  6, 3};
    tbl[5] = '{8'hF0, 26, 5};
    for (int t = 0; t < 6; t++) begin
      run_vector(tbl[t].spikes, 0, cur, lat);
      check($sformatf("tbl%0d_current", t), cur, tbl[t].exp_cur);
      check($sformatf("tbl%0d_latency", t), lat, tbl[t].exp_lat);
      if (t == 0) check("tbl0_skip", int'(skip_count), 0);
      if (t == 1) check("tbl1_skip", int'(skip_count), 8);
    end
    check("tbl_skip_total", int'(skip_count), skip_m);

    // Clamp both ends.
    for (int i = 0; i < 8; i++) load_w(i, -128);
    run_vector(8'hFF, 0, cur, lat);
    check("neg_clamp", cur, 0);
    for (int i = 0; i < 8; i++) load_w(i, 127);
    run_vector(8'hFF, 0, cur, lat);
    check("pos_clamp", cur, 255);

    // Mixed signs with a stalled consumer and an ignored competing input.
    load_w(3, -20);
    load_w(5, 50);
    run_vector(8'h28, 0, cur, lat);
    check("mixed_current", cur, 30);
    check("mixed_latency", lat, 3);
    run_vector(8'h28, 5, cur, lat);
    check("stall_current", cur, 30);
    check("stall_skip", int'(skip_count), skip_m);

    // Write w[2] in the very cycle SCAN reads it: the old value is summed.
    load_w(0, 10);
    load_w(1, 20);
    load_w(2, 30);
    in_valid = 1'b1; in_spikes = 8'h07;
    tick();
    in_valid = 1'b0;
    skip_m += 5;
    tick();
    tick();
    w_load = 1'b1; w_addr = 3'd2; w_data = 8'd100;
    tick();
    w_load = 1'b0;
    w_m[2] = 100;
    check("wr_scan_valid", int'(out_valid), 1);
    check("wr_scan_current", int'(out_current), 60);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_vector(8'h04, 0, cur, lat);
    check("wr_scan_new_weight", cur, 100);

    // Reset in mid-SCAN drops the operation and clears everything.
    in_valid = 1'b1; in_spikes = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();
    check("midscan_in_ready", int'(in_ready), 1);
    check("midscan_out_valid", int'(out_valid), 0);
    check("midscan_current", int'(out_current), 0);
    check("midscan_skip", int'(skip_count), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) w_m[i] = 0;
    skip_m = 0;
    run_vector(8'hFF, 0, cur, lat);
    check("post_rst_current", cur, 0);
    check("post_rst_latency", lat, 9);

    // Randomized traffic against the arithmetic model.
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 1) == 1)
        load_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      sp = 8'($urandom);
      run_vector(sp, int'($urandom_range(0, 2)), cur, lat);
      check("rand_current", cur, model_cur(sp));
      check("rand_latency", lat, ones(sp) + 1);
      check("rand_skip", int'(skip_count), skip_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
